// File: rtl/rom_dl_router.sv
// ROM download router: decodes data_io byte writes into regions,
// packs byte pairs, queues words and drives a toggle-handshake SDRAM port.
module rom_dl_router #(
  parameter int NREG = 4,
  parameter int AW = 25,
  parameter int SAW = 23,
  parameter logic [NREG*AW-1:0] REG_BASE =
    {25'h20000, 25'h10000, 25'h07000, 25'h00000},
  parameter logic [NREG*AW-1:0] REG_END =
    {25'h30000, 25'h18000, 25'h10000, 25'h07000},
  parameter logic [NREG*SAW-1:0] REG_SDW =
    {23'h20000, 23'h10000, 23'h08000, 23'h00000},
  parameter int PACK = 1,
  parameter int DEPTH = 4,
  parameter logic [7:0] ROM_INDEX = 8'h00,
  parameter int HOLD = 1024
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  input  logic           ioctl_download,
  input  logic [7:0]     ioctl_index,
  input  logic           ioctl_wr,
  input  logic [AW-1:0]  ioctl_addr,
  input  logic [7:0]     ioctl_dout,
  input  logic           user_reset,
  output logic           sd_req,
  input  logic           sd_ack,
  output logic [SAW-1:0] sd_a,
  output logic [1:0]     sd_ds,
  output logic [15:0]    sd_d,
  output logic           sd_we,
  output logic           rom_loaded,
  output logic           core_reset,
  output logic           overflow,
  output logic           unmapped
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = SAW + 18;
  localparam int HW = $clog2(HOLD + 2);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_EVEN  = 1'b1;

  logic           wr_d, dl_d, dl_active, busy;
  logic           stg_v;
  logic [AW-1:0]  stg_a;
  logic [7:0]     stg_b;
  logic [0:0]     state, state_nx;
  logic [AW-1:0]  held_a;
  logic [7:0]     held_b;
  logic [RW-1:0]  held_r;
  logic [SAW-1:0] held_w;
  logic           hit;
  logic [RW-1:0]  rsel;
  logic [SAW-1:0] word;
  logic           push, consume, hold_new, miss;
  logic [EW-1:0]  pdat;
  logic [EW-1:0]  mem [DEPTH];
  logic [PW:0]    wp, rp;
  logic           full, empty, push_ok, acked;
  logic           accept, dl_start, done, draining;
  logic [HW-1:0]  hold_cnt;

  assign accept = ioctl_wr & ~wr_d & ioctl_download &
                  (ioctl_index == ROM_INDEX);
  assign dl_start = ioctl_download & ~dl_d &
                    (ioctl_index == ROM_INDEX);

  assign empty = (wp == rp);
  assign full = (wp[PW] != rp[PW]) &&
                (wp[PW-1:0] == rp[PW-1:0]);
  assign push_ok = push & ~full;
  assign acked = (sd_req == sd_ack);

  // Loop runs high to low so the lowest matching region wins.
  always_comb begin
    hit = 1'b0;
    rsel = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (stg_a >= REG_BASE[i*AW +: AW] &&
          stg_a < REG_END[i*AW +: AW]) begin
        hit = 1'b1;
        rsel = RW'(i);
      end
    end
    word = REG_SDW[rsel*SAW +: SAW] +
           SAW'((stg_a - REG_BASE[rsel*AW +: AW]) >> 1);
  end

  always_comb begin
    push = 1'b0;
    pdat = '0;
    consume = 1'b0;
    hold_new = 1'b0;
    miss = 1'b0;
    state_nx = state;
    if (PACK == 0) begin
      if (stg_v) begin
        consume = 1'b1;
        if (hit) begin
          push = 1'b1;
          pdat = {word, stg_a[0], ~stg_a[0], stg_b, stg_b};
        end else begin
          miss = 1'b1;
        end
      end
    end else if (state == ST_EMPTY) begin
      if (stg_v) begin
        consume = 1'b1;
        if (!hit) begin
          miss = 1'b1;
        end else if (!stg_a[0]) begin
          hold_new = 1'b1;
          state_nx = ST_EVEN;
        end else begin
          push = 1'b1;
          pdat = {word, 2'b10, stg_b, stg_b};
        end
      end
    end else begin
      if (stg_v && hit && rsel == held_r &&
          stg_a == held_a + 1'b1) begin
        consume = 1'b1;
        push = 1'b1;
        pdat = {held_w, 2'b11, stg_b, held_b};
        state_nx = ST_EMPTY;
      end else if (stg_v || !ioctl_download) begin
        // Stage stays valid: the new byte is re-decoded next cycle.
        push = 1'b1;
        pdat = {held_w, 2'b01, held_b, held_b};
        state_nx = ST_EMPTY;
      end
    end
  end

  assign draining = stg_v | (state != ST_EMPTY) | ~empty | busy;
  assign done = dl_active & ~ioctl_download & ~dl_d & ~draining &
                acked;

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wp[PW-1:0]] <= pdat;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_d <= 1'b0;
      dl_d <= 1'b0;
      dl_active <= 1'b0;
      busy <= 1'b0;
      stg_v <= 1'b0;
      stg_a <= '0;
      stg_b <= '0;
      state <= ST_EMPTY;
      held_a <= '0;
      held_b <= '0;
      held_r <= '0;
      held_w <= '0;
      wp <= '0;
      rp <= '0;
      sd_req <= 1'b0;
      sd_a <= '0;
      sd_ds <= '0;
      sd_d <= '0;
      sd_we <= 1'b0;
      rom_loaded <= 1'b0;
      overflow <= 1'b0;
      unmapped <= 1'b0;
      hold_cnt <= HW'(HOLD);
    end else begin
      wr_d <= ioctl_wr;
      dl_d <= ioctl_download;
      if (accept) begin
        stg_v <= 1'b1;
        stg_a <= ioctl_addr;
        stg_b <= ioctl_dout;
      end else if (consume) begin
        stg_v <= 1'b0;
      end
      state <= state_nx;
      if (hold_new) begin
        held_a <= stg_a;
        held_b <= stg_b;
        held_r <= rsel;
        held_w <= word;
      end
      if (push_ok) wp <= wp + 1'b1;
      if (!busy && !empty && acked) begin
        {sd_a, sd_ds, sd_d} <= mem[rp[PW-1:0]];
        sd_req <= ~sd_req;
        busy <= 1'b1;
      end else if (busy && acked) begin
        rp <= rp + 1'b1;
        busy <= 1'b0;
      end
      if (dl_start) begin
        overflow <= 1'b0;
        unmapped <= 1'b0;
        rom_loaded <= 1'b0;
        dl_active <= 1'b1;
      end else begin
        if (push && full) overflow <= 1'b1;
        if (miss) unmapped <= 1'b1;
        if (done) begin
          rom_loaded <= 1'b1;
          dl_active <= 1'b0;
        end
      end
      sd_we <= ioctl_download | (sd_we & draining);
      // Reloading while held covers both the load and user-reset fall cases.
      if (user_reset || !rom_loaded) hold_cnt <= HW'(HOLD);
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign core_reset = user_reset | ~rom_loaded | (hold_cnt != '0);

endmodule
